// File: rtl/accel_stream_master.sv
// Streams ifmap/filter buffers to a convolution accelerator and collects its serial results.
// Optional watchdog on the result phase is enabled by defining ACCEL_STREAM_TIMEOUT_EN.
module accel_stream_master #(
  parameter int IFMAP   = 5,
  parameter int FILTER  = 3,
  parameter int OUT     = IFMAP - FILTER + 1,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       acc_en,
  output logic [7:0] acc_ifmap,
  output logic [7:0] acc_filter,
  input  logic [7:0] acc_out,
  input  logic       acc_out_valid,
  input  logic       acc_done,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int NI = IFMAP * IFMAP;
  localparam int NF = FILTER * FILTER;
  localparam int NO = OUT * OUT;
  localparam int AI = (NI > 1) ? $clog2(NI) : 1;
  localparam int AF = (NF > 1) ? $clog2(NF) : 1;
  localparam int AO = (NO > 1) ? $clog2(NO) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_LOAD, S_WAIT, S_RECV, S_FINISH} state_t;

  state_t     r_state;
  logic [8:0] r_lcnt;
  logic [8:0] r_rcnt;
  logic [7:0] r_ifmap  [NI];
  logic [7:0] r_filter [NF];
  logic [7:0] r_result [NO];
  logic       w_res_we;

`ifdef ACCEL_STREAM_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] r_wdog;
`else
  // TIMEOUT only matters when the watchdog is built in.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // Host writes only land while the engine is idle; buffers are never reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      if (!wr_sel && int'(wr_addr) < NI) r_ifmap[wr_addr[AI-1:0]] <= wr_data;
      if (wr_sel && int'(wr_addr) < NF)  r_filter[wr_addr[AF-1:0]] <= wr_data;
    end
  end

  assign w_res_we = (r_state == S_WAIT || r_state == S_RECV) && acc_out_valid &&
                    (r_rcnt < 9'(NO));

  always_ff @(posedge clk) begin
    if (w_res_we) r_result[r_rcnt[AO-1:0]] <= acc_out;
  end

  always_ff @(posedge clk) begin
    if (rst)                    rd_data <= 8'd0;
    else if (int'(rd_addr) < NO) rd_data <= r_result[rd_addr[AO-1:0]];
    else                        rd_data <= 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lcnt     <= 9'd0;
      r_rcnt     <= 9'd0;
      acc_en     <= 1'b0;
      acc_ifmap  <= 8'd0;
      acc_filter <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef ACCEL_STREAM_TIMEOUT_EN
      r_wdog     <= '0;
`endif
    end else begin
      acc_en <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LAUNCH;
            acc_en  <= 1'b1;
            busy    <= 1'b1;
            error   <= 1'b0;
            r_lcnt  <= 9'd0;
            r_rcnt  <= 9'd0;
`ifdef ACCEL_STREAM_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
        end
        // Outputs are registered, so the byte for load cycle k is fetched one state earlier.
        S_LAUNCH, S_LOAD: begin
          if (r_lcnt == 9'(NI)) begin
            acc_ifmap  <= 8'd0;
            acc_filter <= 8'd0;
            r_state    <= S_WAIT;
          end else begin
            acc_ifmap  <= r_ifmap[r_lcnt[AI-1:0]];
            acc_filter <= (r_lcnt < 9'(NF)) ? r_filter[r_lcnt[AF-1:0]] : 8'd0;
            r_lcnt     <= r_lcnt + 9'd1;
            r_state    <= S_LOAD;
          end
        end
        S_WAIT, S_RECV: begin
`ifdef ACCEL_STREAM_TIMEOUT_EN
          r_wdog <= acc_out_valid ? '0 : r_wdog + WDW'(1);
`endif
          if (w_res_we) begin
            r_rcnt  <= r_rcnt + 9'd1;
            r_state <= S_RECV;
          end
          // A final byte arriving with acc_done still counts as success.
          if (w_res_we && r_rcnt == 9'(NO - 1)) begin
            done    <= 1'b1;
            r_state <= S_FINISH;
          end else if (acc_done) begin
            error   <= 1'b1;
            r_state <= S_FINISH;
          end
`ifdef ACCEL_STREAM_TIMEOUT_EN
          else if (!acc_out_valid && r_wdog == WDW'(TIMEOUT - 1)) begin
            error   <= 1'b1;
            r_state <= S_FINISH;
          end
`endif
        end
        S_FINISH: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_stream_master.sv
// Self-checking bench: table of job scenarios, randomized jobs vs a buffer/stream model, reset corner.
module tb_accel_stream_master;
  localparam int NI = 25;
  localparam int NF = 9;
  localparam int NO = 9;

  logic       clk = 1'b0;
  logic       rst, start, wr_en, wr_sel;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       acc_en;
  logic [7:0] acc_ifmap, acc_filter, acc_out;
  logic       acc_out_valid, acc_done, busy, done, error;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ifm [NI];
  logic [7:0] flt [NF];
  logic [7:0] res [NO];

  typedef struct {
    int nb;
    bit dn;
    bit disturb;
    bit exp_done;
    bit exp_err;
  } vec_t;
  vec_t vt [5];

  accel_stream_master dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .acc_en(acc_en), .acc_ifmap(acc_ifmap), .acc_filter(acc_filter),
    .acc_out(acc_out), .acc_out_valid(acc_out_valid), .acc_done(acc_done),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_flt(input int k);
    return (k < NF) ? flt[k] : 8'd0;
  endfunction

  task automatic wr(input bit sel, input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 8'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < (sel ? NF : NI)) begin
      if (sel) flt[a] = d;
      else     ifm[a] = d;
    end
  endtask

  task automatic run_job(input int nb, input bit dn, input bit disturb,
                         input bit exp_done, input bit exp_err);
    int rc;
    logic [7:0] b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("acc_en_pulse", 32'(acc_en), 32'd1);
    chk("busy_set", 32'(busy), 32'd1);
    chk("error_cleared", 32'(error), 32'd0);
    for (int k = 0; k < NI; k++) begin
      if (disturb && k == 4) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 8'hEE;
        acc_out_valid = 1'b1; acc_out = 8'hAA;
      end else if (disturb && k == 5) begin
        start = 1'b0; wr_sel = 1'b1; wr_addr = 8'd1; wr_data = 8'hDD;
      end else begin
        start = 1'b0; wr_en = 1'b0; acc_out_valid = 1'b0;
      end
      tick();
      chk("ifmap_stream", 32'(acc_ifmap), 32'(ifm[k]));
      chk("filter_stream", 32'(acc_filter), 32'(exp_flt(k)));
      chk("acc_en_low", 32'(acc_en), 32'd0);
    end
    start = 1'b0; wr_en = 1'b0; acc_out_valid = 1'b0;
    tick();
    chk("data_zero_after_load", {16'd0, acc_ifmap, acc_filter}, 32'd0);
    rc = 0;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      b = 8'($urandom_range(0, 255));
      acc_out_valid = 1'b1; acc_out = b; acc_done = dn && (i == nb - 1);
      tick();
      acc_out_valid = 1'b0; acc_done = 1'b0;
      if (rc < NO) begin res[rc] = b; rc++; end
    end
    chk("done_pulse", 32'(done), 32'(exp_done));
    chk("error_at_finish", 32'(error), 32'(exp_err));
    chk("busy_in_finish", 32'(busy), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("error_sticky", 32'(error), 32'(exp_err));
  endtask

  task automatic readback();
    for (int a = 0; a <= NO; a++) begin
      rd_addr = 8'(a);
      tick();
      chk("rd_data", 32'(rd_data), (a < NO) ? 32'(res[a]) : 32'd0);
    end
    rd_addr = 8'd200;
    tick();
    chk("rd_out_of_range", 32'(rd_data), 32'd0);
  endtask

  initial begin
    int nb;
    bit dn;
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
    rd_addr = 8'd0; acc_out = 8'd0; acc_out_valid = 1'b0; acc_done = 1'b0;
    vt[0] = '{9, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{5, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[2] = '{9, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{3, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4] = '{9, 1'b1, 1'b0, 1'b1, 1'b0};
    tick(); tick();
    chk("rst_acc_en", 32'(acc_en), 32'd0);
    chk("rst_data", {16'd0, acc_ifmap, acc_filter}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NI; i++) wr(1'b0, i, 8'(i + 1));
    for (int i = 0; i < NF; i++) wr(1'b1, i, 8'(i + 1));
    wr(1'b0, 35, 8'h77);
    wr(1'b1, 12, 8'h66);

    for (int v = 0; v < 5; v++) begin
      run_job(vt[v].nb, vt[v].dn, vt[v].disturb, vt[v].exp_done, vt[v].exp_err);
      readback();
    end

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < NI; i++) wr(1'b0, i, 8'($urandom_range(0, 255)));
      for (int i = 0; i < NF; i++) wr(1'b1, i, 8'($urandom_range(0, 255)));
      nb = $urandom_range(1, NO);
      dn = (nb < NO) ? 1'b1 : 1'($urandom_range(0, 1));
      run_job(nb, dn, 1'($urandom_range(0, 1)), nb == NO, nb != NO);
      readback();
    end

    // Reset in the middle of the result phase, then a clean job on retained buffers.
    start = 1'b1; tick(); start = 1'b0;
    repeat (NI + 1) tick();
    for (int i = 0; i < 3; i++) begin
      acc_out_valid = 1'b1; acc_out = 8'(8'h40 + i);
      tick();
      res[i] = 8'(8'h40 + i);
    end
    acc_out_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_acc_en", 32'(acc_en), 32'd0);
    chk("midrst_data", {16'd0, acc_ifmap, acc_filter}, 32'd0);
    chk("midrst_flags", {29'd0, busy, done, error}, 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    tick();
    run_job(NO, 1'b0, 1'b0, 1'b1, 1'b0);
    readback();

`ifdef ACCEL_STREAM_TIMEOUT_EN
    begin : wdog_test
      int t;
      t = 0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (NI + 1) tick();
      while (busy && t < 1100) begin tick(); t++; end
      chk("wdog_busy_fall", 32'(busy), 32'd0);
      chk("wdog_error", 32'(error), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
